// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round-sequencing controller.
// Holds the command opcodes, controller FSM states and the xtime helper.
package aes_pkg;

    typedef logic [7:0]   aes_byte;
    typedef logic [127:0] aes_128;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_KEY   = 2'd1,
        OP_ENC   = 2'd2,
        OP_ABORT = 2'd3
    } opcode;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_EXP   = 3'd1,
        ENC_INIT  = 3'd2,
        ENC_ROUND = 3'd3,
        ENC_FINAL = 3'd4
    } ctrl_state;

    localparam aes_byte RCON_INIT  = 8'h01;
    localparam aes_byte RCON_POLY  = 8'h1B;
    localparam int      NUM_ROUNDS = 10;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic aes_byte xtime(input aes_byte b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Registered round-constant generator: load restarts at RCON_INIT,
// step advances the constant by one xtime.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_step,
    output aes_byte o_rcon
);

    aes_byte r_rcon;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcon <= RCON_INIT;
        end else if (i_load) begin
            r_rcon <= RCON_INIT;
        end else if (i_step) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_ctrl.sv
// Round-sequencing controller for the iterative AES-128 core.
// Optional feature macro AES_CTRL_ABORT_EN: OP_ABORT cancels a busy command.
module aes_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  aes_pkg::opcode opcode_i,
    output logic          busy_o,
    output logic          key_ready_o,
    output logic          cipher_ready_o,
    output logic          err_o,
    output aes_byte       r_con_o,
    output logic [3:0]    round_o,
    output logic          key_load_o,
    output logic          key_gen_en_o,
    output logic          state_load_o,
    output logic          round_en_o,
    output logic          final_round_o,
    output logic          cipher_latch_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_MIX   = 4'(NUM_ROUNDS - 1);

    ctrl_state  r_state;
    ctrl_state  w_next;
    logic [3:0] r_round;
    logic       r_busy;
    logic       r_keyReady;
    logic       r_cipherReady;
    logic       r_err;

    logic w_abort;
    logic w_reject;
    logic w_keyLoad;
    logic w_keyGenEn;
    logic w_stateLoad;
    logic w_roundEn;
    logic w_finalRound;
    logic w_cipherLatch;
    logic w_rconLoad;
    logic w_rconStep;

    always_comb begin
        w_next        = r_state;
        w_abort       = 1'b0;
        w_reject      = 1'b0;
        w_keyLoad     = 1'b0;
        w_keyGenEn    = 1'b0;
        w_stateLoad   = 1'b0;
        w_roundEn     = 1'b0;
        w_finalRound  = 1'b0;
        w_cipherLatch = 1'b0;
`ifdef AES_CTRL_ABORT_EN
        w_abort = (r_state != IDLE) && start_i && (opcode_i == OP_ABORT);
`endif
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    case (opcode_i)
                        OP_KEY: begin
                            w_keyLoad = 1'b1;
                            w_next    = KEY_EXP;
                        end
                        OP_ENC: begin
                            if (r_keyReady) begin
                                w_stateLoad = 1'b1;
                                w_next      = ENC_ROUND;
                            end else begin
                                w_reject = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            KEY_EXP: begin
                w_keyGenEn = 1'b1;
                if (r_round == LAST_ROUND) begin
                    w_next = IDLE;
                end
            end
            ENC_ROUND: begin
                w_roundEn = 1'b1;
                if (r_round == LAST_MIX) begin
                    w_next = ENC_FINAL;
                end
            end
            ENC_FINAL: begin
                w_roundEn     = 1'b1;
                w_finalRound  = 1'b1;
                w_cipherLatch = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // An abort suppresses the strobes of the cycle it arrives in.
        if (w_abort) begin
            w_next        = IDLE;
            w_keyGenEn    = 1'b0;
            w_roundEn     = 1'b0;
            w_finalRound  = 1'b0;
            w_cipherLatch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_round       <= 4'd0;
            r_busy        <= 1'b0;
            r_keyReady    <= 1'b0;
            r_cipherReady <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_err   <= w_reject;
            if (w_next == IDLE) begin
                r_round <= 4'd0;
            end else if (r_state == IDLE) begin
                r_round <= 4'd1;
            end else begin
                r_round <= r_round + 4'd1;
            end
            if (w_keyLoad) begin
                r_keyReady    <= 1'b0;
                r_cipherReady <= 1'b0;
            end else if (w_keyGenEn && (r_round == LAST_ROUND)) begin
                r_keyReady <= 1'b1;
            end
            if (w_stateLoad) begin
                r_cipherReady <= 1'b0;
            end else if (w_cipherLatch) begin
                r_cipherReady <= 1'b1;
            end
        end
    end

    // The constant only walks while expansion continues; it snaps back otherwise.
    assign w_rconLoad = (w_next != KEY_EXP);
    assign w_rconStep = (r_state == KEY_EXP) && (w_next == KEY_EXP);

    aes_rcon_gen u_rconGen (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_rconLoad),
        .i_step (w_rconStep),
        .o_rcon (r_con_o)
    );

    assign busy_o         = r_busy;
    assign key_ready_o    = r_keyReady;
    assign cipher_ready_o = r_cipherReady;
    assign err_o          = r_err;
    assign round_o        = r_round;
    assign key_load_o     = w_keyLoad;
    assign key_gen_en_o   = w_keyGenEn;
    assign state_load_o   = w_stateLoad;
    assign round_en_o     = w_roundEn;
    assign final_round_o  = w_finalRound;
    assign cipher_latch_o = w_cipherLatch;

endmodule

// File: tb/tb_aes_ctrl.sv
// Self-checking bench for aes_ctrl: table of commands plus hand-built corner
// sequences, all compared cycle by cycle through a scoreboard queue.
module tb_aes_ctrl;
    import aes_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       keyReady;
        logic       cipherReady;
        logic       err;
        logic [7:0] rcon;
        logic [3:0] round;
        logic       keyLoad;
        logic       keyGenEn;
        logic       stateLoad;
        logic       roundEn;
        logic       finalRound;
        logic       cipherLatch;
    } outRec;

    typedef struct {
        logic  rst;
        logic  start;
        opcode op;
        logic  check;
        string name;
        outRec exp;
    } sbItem;

    typedef struct {
        opcode op;
        string name;
        logic  expKeyReady;
        logic  expCipherReady;
    } vecRec;

    logic       clk;
    logic       rst;
    logic       start_i;
    opcode      opcode_i;
    logic       busy_o, key_ready_o, cipher_ready_o, err_o;
    aes_byte    r_con_o;
    logic [3:0] round_o;
    logic       key_load_o, key_gen_en_o, state_load_o;
    logic       round_en_o, final_round_o, cipher_latch_o;

    int         checks;
    int         failures;
    sbItem      sbQ[$];
    logic       mKeyReady;
    logic       mCipherReady;
    logic [7:0] rconTab [10];
    vecRec      vecs [10];

    aes_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .opcode_i       (opcode_i),
        .busy_o         (busy_o),
        .key_ready_o    (key_ready_o),
        .cipher_ready_o (cipher_ready_o),
        .err_o          (err_o),
        .r_con_o        (r_con_o),
        .round_o        (round_o),
        .key_load_o     (key_load_o),
        .key_gen_en_o   (key_gen_en_o),
        .state_load_o   (state_load_o),
        .round_en_o     (round_en_o),
        .final_round_o  (final_round_o),
        .cipher_latch_o (cipher_latch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outRec actualRec();
        outRec a;
        a = '{busy_o, key_ready_o, cipher_ready_o, err_o, r_con_o, round_o,
              key_load_o, key_gen_en_o, state_load_o, round_en_o,
              final_round_o, cipher_latch_o};
        return a;
    endfunction

    function automatic outRec idleRec(input logic kr, input logic cr);
        outRec e;
        e = '0;
        e.keyReady    = kr;
        e.cipherReady = cr;
        e.rcon        = 8'h01;
        return e;
    endfunction

    function automatic sbItem mkItem(input logic s, input opcode op,
                                     input string name, input outRec e);
        sbItem it;
        it.rst   = 1'b0;
        it.start = s;
        it.op    = op;
        it.check = 1'b1;
        it.name  = name;
        it.exp   = e;
        return it;
    endfunction

    task automatic checkOutput(input string name, input outRec exp);
        outRec act;
        act = actualRec();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Push the expected per-cycle trace of one command issued from IDLE.
    task automatic buildTrace(input opcode op, input string name);
        outRec e;
        e = idleRec(mKeyReady, mCipherReady);
        e.keyLoad   = (op == OP_KEY);
        e.stateLoad = (op == OP_ENC) && mKeyReady;
        sbQ.push_back(mkItem(1'b1, op, {name, "_start"}, e));
        if (op == OP_KEY) begin
            for (int i = 1; i <= 10; i++) begin
                e = '0;
                e.busy     = 1'b1;
                e.rcon     = rconTab[i-1];
                e.round    = 4'(i);
                e.keyGenEn = 1'b1;
                sbQ.push_back(mkItem(1'b0, OP_NOP, $sformatf("%s_r%0d", name, i), e));
            end
            mKeyReady    = 1'b1;
            mCipherReady = 1'b0;
        end else if (op == OP_ENC && mKeyReady) begin
            for (int i = 1; i <= 10; i++) begin
                e = idleRec(1'b1, 1'b0);
                e.busy        = 1'b1;
                e.round       = 4'(i);
                e.roundEn     = 1'b1;
                e.finalRound  = (i == 10);
                e.cipherLatch = (i == 10);
                sbQ.push_back(mkItem(1'b0, OP_NOP, $sformatf("%s_r%0d", name, i), e));
            end
            mCipherReady = 1'b1;
        end else if (op == OP_ENC) begin
            e = idleRec(mKeyReady, mCipherReady);
            e.err = 1'b1;
            sbQ.push_back(mkItem(1'b0, OP_NOP, {name, "_err"}, e));
        end
    endtask

    task automatic applyStimulus();
        sbItem it;
        while (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            rst      = it.rst;
            start_i  = it.start;
            opcode_i = it.op;
            @(negedge clk);
            if (it.check) checkOutput(it.name, it.exp);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rconTab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                     8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        vecs = '{
            '{OP_ENC,   "enc_nokey",   1'b0, 1'b0},
            '{OP_NOP,   "nop",         1'b0, 1'b0},
            '{OP_ABORT, "abort_idle",  1'b0, 1'b0},
            '{OP_KEY,   "key1",        1'b1, 1'b0},
            '{OP_ENC,   "enc1",        1'b1, 1'b1},
            '{OP_NOP,   "nop2",        1'b1, 1'b1},
            '{OP_ENC,   "enc2",        1'b1, 1'b1},
            '{OP_KEY,   "key2",        1'b1, 1'b0},
            '{OP_ABORT, "abort_idle2", 1'b1, 1'b0},
            '{OP_ENC,   "enc3",        1'b1, 1'b1}
        };
        mKeyReady    = 1'b0;
        mCipherReady = 1'b0;
        rst      = 1'b1;
        start_i  = 1'b0;
        opcode_i = OP_NOP;
        @(posedge clk);
        #1;
        begin
            sbItem it;
            it = mkItem(1'b0, OP_NOP, "reset", idleRec(1'b0, 1'b0));
            it.rst = 1'b1;
            sbQ.push_back(it);
        end
        applyStimulus();

        // Commands issued back to back; each starts in the first IDLE cycle.
        for (int v = 0; v < 10; v++) begin
            buildTrace(vecs[v].op, vecs[v].name);
            applyStimulus();
            checkFlag({vecs[v].name, "_keyReady"}, key_ready_o, vecs[v].expKeyReady);
            checkFlag({vecs[v].name, "_cipherReady"}, cipher_ready_o, vecs[v].expCipherReady);
        end

        // OP_KEY strobed mid-encryption must be ignored.
        buildTrace(OP_ENC, "enc_keyhit");
        sbQ[4].start = 1'b1;
        sbQ[4].op    = OP_KEY;
        buildTrace(OP_NOP, "after_keyhit");
        applyStimulus();

        // Synchronous reset at T+5 of encryption.
        buildTrace(OP_ENC, "enc_rst");
        sbQ[5].rst = 1'b1;
        while (sbQ.size() > 6) void'(sbQ.pop_back());
        sbQ.push_back(mkItem(1'b0, OP_NOP, "post_rst", idleRec(1'b0, 1'b0)));
        mKeyReady    = 1'b0;
        mCipherReady = 1'b0;
        buildTrace(OP_ENC, "enc_after_rst");
        applyStimulus();

        // OP_ABORT at T+3 of key expansion.
        buildTrace(OP_KEY, "key_abort");
        sbQ[3].start = 1'b1;
        sbQ[3].op    = OP_ABORT;
`ifdef AES_CTRL_ABORT_EN
        sbQ[3].check = 1'b0;
        while (sbQ.size() > 4) void'(sbQ.pop_back());
        sbQ.push_back(mkItem(1'b0, OP_NOP, "aborted_idle", idleRec(1'b0, 1'b0)));
        mKeyReady    = 1'b0;
        mCipherReady = 1'b0;
`endif
        buildTrace(OP_NOP, "after_abort");
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_ctrl.md
# aes_ctrl

- Round-sequencing controller for the iterative AES-128 core.
- Accepts commands from the bench/host side of the AES interface: `start_i`, `opcode_i`, `key_i`, `plain_text_i`.
- Drives the status side of the same interface: `key_ready_o`, `cipher_ready_o`, `busy_o`.
- Drives the strobes, round index and round constant that step the key-generation and encryption datapaths through key expansion and the ten cipher rounds.

## Interface
- `NUM_ROUNDS`, default 10: cipher rounds; only 10 (AES-128) is supported.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: command strobe, sampled on rising edge.
- `opcode_i` in `aes_pkg::opcode`: `OP_NOP`=0, `OP_KEY`=1, `OP_ENC`=2, `OP_ABORT`=3.
- `busy_o` out 1: a command is in progress.
- `key_ready_o` out 1: round keys are valid; sticky.
- `cipher_ready_o` out 1: `cipher_o` is valid; level.
- `err_o` out 1: one-cycle pulse when a command is rejected.
- `r_con_o` out `aes_pkg::aes_byte`: round constant to key_gen.
- `round_o` out 4: current round index, 0..10.
- `key_load_o` out 1: load `key_i` into the key register.
- `key_gen_en_o` out 1: key_gen computes round key `round_o` this cycle.
- `state_load_o` out 1: load `plain_text_i` XOR round key 0.
- `round_en_o` out 1: apply one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey).
- `final_round_o` out 1: qualifies `round_en_o`; skip MixColumns.
- `cipher_latch_o` out 1: capture the datapath state into `cipher_o`.

## Operation
- FSM states: `IDLE`, `KEY_EXP`, `ENC_INIT`, `ENC_ROUND`, `ENC_FINAL`.
- Commands are accepted only in `IDLE` with `start_i`=1. In other states `start_i` is ignored (see Configuration for `OP_ABORT`).
- `OP_KEY` in `IDLE`:
  - `key_load_o`=1 that cycle; `key_ready_o` cleared; `cipher_ready_o` cleared.
  - Next state `KEY_EXP` with `round_o`=1, `r_con_o`=8'h01.
- `KEY_EXP`:
  - `key_gen_en_o`=1 every cycle.
  - `round_o` increments; `r_con_o` advances as xtime: {r[6:0],0} ^ (r[7] ? 8'h1B : 0).
  - After `round_o`=10 (`r_con_o`=8'h36): set `key_ready_o`, return to `IDLE`.
- `OP_ENC` in `IDLE` with `key_ready_o`=1:
  - `state_load_o`=1, `round_o`=0, `cipher_ready_o` cleared.
  - Next state `ENC_ROUND`, `round_o`=1.
- `OP_ENC` with `key_ready_o`=0: `err_o` pulses; state stays `IDLE`; no strobes.
- `ENC_ROUND`: `round_en_o`=1 for rounds 1..9, `round_o` increments; after round 9 go to `ENC_FINAL`.
- `ENC_FINAL`:
  - `round_en_o`=1, `final_round_o`=1, `round_o`=10, `cipher_latch_o`=1.
  - `cipher_ready_o` set next cycle; return to `IDLE`.
- `OP_NOP` has no effect. `OP_ABORT` in `IDLE` has no effect.
- `busy_o`=1 in every state except `IDLE` (registered from next-state).
- `r_con_o` holds 8'h01 outside `KEY_EXP`.

## Timing
- Reset values: state `IDLE`; `busy_o`, `key_ready_o`, `cipher_ready_o`, `err_o` and all strobes = 0; `round_o`=0; `r_con_o`=8'h01.
- Reset mid-operation: abandons the command and clears `key_ready_o`, so a fresh `OP_KEY` is required.
- Key expansion, with start sampled at edge T:
  - `key_load_o` high during T.
  - `key_gen_en_o` high T+1..T+10.
  - `key_ready_o`=1 from T+11; `busy_o`=1 T+1..T+10.
- Encryption, with start sampled at edge T:
  - `state_load_o` during T.
  - `round_en_o` T+1..T+10; `final_round_o` and `cipher_latch_o` at T+10.
  - `cipher_ready_o`=1 from T+11.
- Back-to-back: a new `start_i` is accepted in the first `IDLE` cycle after completion, i.e. T+11.
- `err_o` is asserted the cycle after the rejected start.

## Configuration
- Macro: `AES_CTRL_ABORT_EN`.
- Defined:
  - `start_i` with `OP_ABORT` in any busy state returns the FSM to `IDLE` on the next edge; `busy_o`=0, all strobes 0.
  - Aborting `KEY_EXP` leaves `key_ready_o`=0.
  - Aborting encryption leaves `cipher_ready_o`=0 and `key_ready_o` unchanged.
- Undefined: `OP_ABORT` is ignored everywhere like any other command while busy, and is a no-op in `IDLE`.

## Structure
- `aes_pkg` holds:
  - the `opcode` enum, `aes_byte` and `aes_128`;
  - the FSM state enum `ctrl_state`;
  - `RCON_INIT`=8'h01, `RCON_POLY`=8'h1B, `NUM_ROUNDS`=10.
- One sub-module, `aes_rcon_gen`: a registered xtime round-constant generator with load and step inputs.

## Test plan
- Reset, then `OP_KEY` → `r_con_o` sequence 01,02,04,08,10,20,40,80,1B,36 on T+1..T+10; `key_ready_o`=1 at T+11.
- `OP_ENC` after reset, no key → `err_o` one cycle; `busy_o` stays 0; no `state_load_o`.
- FIPS-197 key 000102…0f, plaintext 00112233…ff, with the datapath attached → `cipher_ready_o` at T+11; `cipher_o`=69c4e0d8…c55a.
- `start_i`/`OP_KEY` pulsed at T+4 during encryption → ignored; `key_ready_o` stays 1; cipher is still correct.
- `rst` at T+5 of encryption → next cycle all outputs at reset values, `key_ready_o`=0.
- With `AES_CTRL_ABORT_EN`: `OP_ABORT` at T+3 of `KEY_EXP` → `IDLE` at T+4 with `key_ready_o`=0. Without the macro: expansion completes at T+11.
